// File: rtl/bit_count_seq.sv
// Sequential bit-statistics engine: ones, zeros, trailing or leading zeros of a WIDTH-bit operand, one bit per clock.
// Define BITCOUNT_PARITY_EN to also report the operand parity captured at the accepting edge.
module bit_count_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in,
  input  logic [1:0]                   mode,
  input  logic                         start,
  output logic [$clog2(WIDTH+1)-1:0]   result,
  output logic                         busy,
  output logic                         done,
  output logic                         parity
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] MODE_ONES     = 2'b00;
  localparam logic [1:0] MODE_ZEROS    = 2'b01;
  localparam logic [1:0] MODE_TRAILING = 2'b10;
  localparam logic [1:0] MODE_LEADING  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a, a_nx;
  logic [1:0]       m, m_nx;
  logic [CW-1:0]    idx, idx_nx;
  logic [CW-1:0]    result_nx;
  logic             busy_nx, done_nx;
  logic             idx_last, term;

  // Termination test on the current shift-register contents
  always_comb begin
    idx_last = (idx == CW'(WIDTH));
    term     = 1'b0;
    case (m)
      MODE_ONES:     term = (a == '0);
      MODE_ZEROS:    term = idx_last;
      MODE_TRAILING: term = a[0] | idx_last;
      MODE_LEADING:  term = a[WIDTH-1] | idx_last;
      default:       term = 1'b1;
    endcase
  end

  always_comb begin
    state_nx  = state;
    a_nx      = a;
    m_nx      = m;
    idx_nx    = idx;
    result_nx = result;
    case (state)
      IDLE: begin
        if (start) begin
          a_nx      = in;
          m_nx      = mode;
          idx_nx    = '0;
          result_nx = '0;
          state_nx  = RUN;
        end
      end
      RUN: begin
        if (term) begin
          state_nx = DONE;
        end else begin
          case (m)
            MODE_ONES: begin
              result_nx = result + CW'(a[0]);
              a_nx      = a >> 1;
            end
            MODE_ZEROS: begin
              result_nx = result + CW'(~a[0]);
              a_nx      = a >> 1;
            end
            MODE_TRAILING: begin
              result_nx = result + CW'(1);
              a_nx      = a >> 1;
            end
            default: begin
              result_nx = result + CW'(1);
              a_nx      = a << 1;
            end
          endcase
          idx_nx = idx + CW'(1);
        end
      end
      DONE: begin
        // start is a level: only its release lets the engine re-arm
        if (!start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == RUN);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      a      <= '0;
      m      <= '0;
      idx    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      a      <= a_nx;
      m      <= m_nx;
      idx    <= idx_nx;
      result <= result_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end

`ifdef BITCOUNT_PARITY_EN
  // Parity of the accepted operand, independent of mode and early exit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    parity <= 1'b0;
    else if (state == IDLE && start) parity <= ^in;
  end
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_bit_count_seq.sv
// Scoreboard bench for bit_count_seq: WIDTH=8 and WIDTH=16 instances, directed operands with hand-computed results.
module tb_bit_count_seq;

  typedef struct {
    logic [7:0] res;
    int         cyc;
    logic       par;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  logic       reset8 = 1'b0;
  logic [7:0] in8 = '0;
  logic [1:0] mode8 = '0;
  logic       start8 = 1'b0;
  logic [3:0] result8;
  logic       busy8, done8, parity8;

  logic        reset16 = 1'b0;
  logic [15:0] in16 = '0;
  logic [1:0]  mode16 = '0;
  logic        start16 = 1'b0;
  logic [4:0]  result16;
  logic        busy16, done16, parity16;

  exp_t sb8[$];
  exp_t sb16[$];

  bit_count_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .in(in8), .mode(mode8), .start(start8),
    .result(result8), .busy(busy8), .done(done8), .parity(parity8)
  );

  bit_count_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset16), .in(in16), .mode(mode16), .start(start16),
    .result(result16), .busy(busy16), .done(done16), .parity(parity16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic par_of(input logic [15:0] v);
`ifdef BITCOUNT_PARITY_EN
    return ^v;
`else
    return 1'b0 & v[0];
`endif
  endfunction

  // Monitors: pop one expectation on every rising done
  logic prev8 = 1'b0;
  exp_t e8;
  always @(negedge clk) begin
    if (done8 === 1'b1 && prev8 !== 1'b1) begin
      if (sb8.size() == 0) begin
        n_total++;
        $display("FAIL w8_unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        e8 = sb8.pop_front();
        check("w8_result", 32'(result8), 32'(e8.res));
        check("w8_done_cycle", cyc, e8.cyc);
        check("w8_parity", 32'(parity8), 32'(e8.par));
      end
    end
    prev8 = done8;
  end

  logic prev16 = 1'b0;
  exp_t e16;
  always @(negedge clk) begin
    if (done16 === 1'b1 && prev16 !== 1'b1) begin
      if (sb16.size() == 0) begin
        n_total++;
        $display("FAIL w16_unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        e16 = sb16.pop_front();
        check("w16_result", 32'(result16), 32'(e16.res));
        check("w16_done_cycle", cyc, e16.cyc);
        check("w16_parity", 32'(parity16), 32'(e16.par));
      end
    end
    prev16 = done16;
  end

  // Issue one WIDTH=8 op; p = processing cycles, r = expected result
  task automatic run8(input logic [7:0] op, input logic [1:0] md, input int p,
                      input logic [3:0] r, input bit drop);
    exp_t e;
    int   n;
    @(negedge clk);
    in8 = op; mode8 = md; start8 = 1'b1;
    e.res = 8'(r); e.cyc = cyc + p + 2; e.par = par_of(16'(op));
    sb8.push_back(e);
    @(negedge clk);
    if (drop) begin
      start8 = 1'b0; in8 = ~op; mode8 = ~md;
    end
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done8 !== 1'b1) begin
      n_total++;
      $display("FAIL w8_timeout: got no done expected done within 40 cycles (op=%0h)", op);
      start8 = 1'b0;
    end else if (!drop) begin
      @(negedge clk);
      check("w8_done_hold", 32'(done8), 32'd1);
      check("w8_result_frozen", 32'(result8), 32'(r));
      start8 = 1'b0;
    end
    @(negedge clk);
    check("w8_done_fall", 32'(done8), 32'd0);
    check("w8_result_keep", 32'(result8), 32'(r));
  endtask

  task automatic run16(input logic [15:0] op, input logic [1:0] md, input int p, input logic [4:0] r);
    exp_t e;
    int   n;
    @(negedge clk);
    in16 = op; mode16 = md; start16 = 1'b1;
    e.res = 8'(r); e.cyc = cyc + p + 2; e.par = par_of(op);
    sb16.push_back(e);
    n = 0;
    @(negedge clk);
    while (done16 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (done16 !== 1'b1) begin
      n_total++;
      $display("FAIL w16_timeout: got no done expected done within 60 cycles (op=%0h)", op);
    end
    start16 = 1'b0;
    @(negedge clk);
    check("w16_done_fall", 32'(done16), 32'd0);
    check("w16_result_keep", 32'(result16), 32'(r));
  endtask

  initial begin
    #1;
    check("rst_result", 32'(result8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_parity", 32'(parity8), 32'd0);
    @(negedge clk);
    reset8 = 1'b1; reset16 = 1'b1;
    @(negedge clk);

    run8(8'b0010_0100, 2'b00, 6, 4'd2, 1'b0);

    // Asynchronous reset while idle with a held result
    #2 reset8 = 1'b0;
    #1;
    check("midrst_result", 32'(result8), 32'd0);
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    @(negedge clk);
    reset8 = 1'b1;
    @(negedge clk);
    check("idle_after_rst", 32'(busy8), 32'd0);

    run8(8'h00,        2'b00, 0, 4'd0, 1'b0);
    run8(8'hFF,        2'b01, 8, 4'd0, 1'b0);
    run8(8'b0101_0000, 2'b10, 4, 4'd4, 1'b1);
    run8(8'b0101_0000, 2'b11, 1, 4'd1, 1'b0);
    run8(8'h00,        2'b10, 8, 4'd8, 1'b0);
    run8(8'b0010_0101, 2'b00, 6, 4'd3, 1'b0);

    // WIDTH=16: abort in RUN after E5, then rerun the same operand
    @(negedge clk);
    in16 = 16'h8001; mode16 = 2'b00; start16 = 1'b1;
    repeat (6) @(negedge clk);
    check("w16_busy_mid", 32'(busy16), 32'd1);
    check("w16_progress", 32'(result16), 32'd1);
    #1 reset16 = 1'b0; start16 = 1'b0;
    #1;
    check("w16_abort_result", 32'(result16), 32'd0);
    check("w16_abort_busy", 32'(busy16), 32'd0);
    check("w16_abort_done", 32'(done16), 32'd0);
    @(negedge clk);
    reset16 = 1'b1;
    @(negedge clk);
    run16(16'h8001, 2'b00, 16, 5'd2);

    repeat (3) @(negedge clk);
    check("sb8_drained", 32'(sb8.size()), 32'd0);
    check("sb16_drained", 32'(sb16.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no end of test expected finish before 50000");
    $fatal(1);
  end

endmodule

// File: doc/bit_count_seq.md
Name: bit_count_seq

Overview:
- Parametrised sequential bit-analysis engine; successor to the fixed 8-bit ones counter in the lab datapath.
- Scans a WIDTH-bit operand one bit per clock.
- Returns one of four statistics, selected per operation by a mode input: ones count, zeros count, trailing zeros, leading zeros.
- Start/done level handshake toward the controlling FSM or top-level switches/LEDs.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..64
CW, $clog2(WIDTH+1), result width (derived localparam, not overridable)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
in  input  WIDTH  operand; sampled only on the accepting edge
mode  input  2  00=ones, 01=zeros, 10=trailing zeros, 11=leading zeros; sampled with in
start  input  1  level request
result  output  CW  statistic; valid while done=1
busy  output  1  high in RUN
done  output  1  high in DONE
parity  output  1  optional feature; see below

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; result=0, busy=0, done=0, parity=0. Internal shift register, bit index and latched mode are cleared.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=0: stay in IDLE; result holds its last value.
  - start=1: accept on the edge. Load A<=in, m<=mode, idx<=0, result<=0; go to RUN.
- RUN, evaluated each edge:
  - If the termination condition holds: go to DONE. result is not updated on that edge.
  - Otherwise, process one bit:
    - ones: result += A[0]; A <= A>>1.
    - zeros: result += ~A[0]; A <= A>>1.
    - trailing: result += 1; A <= A>>1.
    - leading: result += 1; A <= A<<1.
    - idx += 1 in all modes.
- Termination conditions:
  - ones: A==0 (early exit).
  - zeros: idx==WIDTH.
  - trailing: A[0]==1 or idx==WIDTH.
  - leading: A[WIDTH-1]==1 or idx==WIDTH.
- Latency: let E0 be the accepting edge and P the number of processing cycles. done rises on edge E(P+1), so the worst case is WIDTH+1 edges.
  - ones: P = index of highest set bit + 1, or 0 if in==0.
  - zeros: P = WIDTH.
  - trailing/leading: P = the resulting count.
- DONE:
  - done=1; result is frozen.
  - Stay while start=1. When start=0, go to IDLE on the next edge; done falls and result holds.
- start is not edge-detected. Holding start through DONE does not retrigger. A new operation requires start to drop to 0 in DONE, and at least one IDLE cycle.
- in and mode changes during RUN or DONE are ignored.
- start drop during RUN: the operation still completes. DONE is then exited on the edge after done rises, giving a one-cycle done pulse.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with all outputs 0. No partial result is retained.
- Arithmetic: result never exceeds WIDTH, so no overflow in CW bits. idx is CW bits wide.

Optional Feature:
- Macro: BITCOUNT_PARITY_EN.
- Defined:
  - parity <= ^in on the accepting edge, held through RUN and DONE.
  - parity is cleared by reset only; valid while done=1.
  - Independent of mode and of early termination.
- Undefined:
  - parity port still present, tied to 0.
  - No extra flops.

Test Plan:
- WIDTH=8, reset low mid-sequence then released, start=0 -> result=0, busy=0, done=0 immediately on reset assert (no clock needed). State stays in IDLE.
- WIDTH=8, in=8'b00100100, mode=00, start held 1 -> busy for 7 edges; done rises on E7 with result=2 and stays while start=1. After start=0, done=0 next edge and result stays 2.
- WIDTH=8, in=8'h00, mode=00 -> done on E1, result=0. Then in=8'hFF, mode=01 -> done on E9, result=0.
- WIDTH=8, in=8'b01010000, mode=10 -> done on E5, result=4. Same in with mode=11 -> done on E2, result=1. in=0 with mode=10 -> result=8, done on E9.
- WIDTH=16, in=16'h8001, mode=00, reset asserted at E5 during RUN -> outputs 0 at once. Restart with the same operand -> done on E17, result=2.
- BITCOUNT_PARITY_EN defined, WIDTH=8, in=8'b00100100 then 8'b00100101 -> parity=0 then 1 at done. Macro undefined -> parity=0 throughout.
